dmem_axi_bridge: RTL and testbench
==================================

Name: dmem_axi_bridge

Overview:
- Data-side responder for the MEM-stage memory request interface (ce/we/sel/addr/data in; busy and read data out).
- Converts each accepted request into exactly one single-beat AXI4 read or write transaction on the master port.
- Holds busy high until the transaction completes, so the MEM stage stalls while a load/store is outstanding.
- Translates the MEM stage's big-endian byte-lane convention (sel[3] = byte at addr[1:0]=00 = data[31:24]) to AXI little-endian lanes.

Parameters:
AXI_ID, 1, constant ARID/AWID driven on every transaction
ID_WIDTH, 4, width of AXI ID fields

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ce_i  in  1  request valid; held stable by MEM while busy_o=1
we_i  in  1  1=store, 0=load
sel_i  in  4  byte select, MEM lane order
addr_i  in  32  physical byte address
data_i  in  32  store data, MEM lane order
busy_o  out  1  request not yet complete
rdata_o  out  32  load data, MEM lane order
err_o  out  1  1-cycle pulse in DONE when RRESP/BRESP != OKAY
arid/araddr/arlen/arsize/arburst/arvalid  out  ID_WIDTH/32/8/3/2/1  AXI read address
arready  in  1
rid/rdata/rresp/rlast/rvalid  in  ID_WIDTH/32/2/1/1  AXI read data
rready  out  1
awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_WIDTH/32/8/3/2/1  AXI write address
awready  in  1
wdata/wstrb/wlast/wvalid  out  32/4/1/1
wready  in  1
bid/bresp/bvalid  in  ID_WIDTH/2/1
bready  out  1

Behaviour:
- States: IDLE, RD_A, RD_D, WR, WR_B, DONE.
- Reset (rst=1 at posedge): state=IDLE; all valid/ready outputs 0; rdata_o=0; err_o=0; latched request regs=0.
  - Reset mid-transaction abandons it; the interconnect is reset together with the core.
- busy_o = ce_i && state!=DONE (combinational).
- IDLE:
  - ce_i=1 latches addr/sel/data/we.
  - Next state WR if we_i=1, else RD_A.
  - ce_i=0: stay in IDLE.
- Field derivation from latched sel:
  - size: 1111 gives 2; 1100 or 0011 gives 1; one-hot gives 0; any other value gives 2.
  - ar/awaddr = latched addr unchanged.
  - len=0, burst=INCR(01), id=AXI_ID.
- RD_A: arvalid=1 until arready sampled high, then RD_D. arvalid deasserts the cycle after the handshake.
- RD_D:
  - rready=1.
  - On rvalid: capture byte-reversed rdata into rdata_o, i.e. {rdata[7:0],rdata[15:8],rdata[23:16],rdata[31:24]}.
  - Record rresp!=00 as a pending error; go to DONE.
  - rid is ignored.
- WR:
  - awvalid and wvalid both assert on entry.
  - Each deasserts independently after its own handshake; AW and W may complete in either order or in the same cycle.
  - When both are done, go to WR_B.
  - wdata = byte-reverse(latched data); wstrb = bit-reverse(latched sel); wlast=1.
- WR_B: bready=1; on bvalid record bresp!=00 as a pending error, then DONE.
- DONE:
  - busy_o=0; rdata_o holds the load result; err_o=pending error.
  - Next state is IDLE unconditionally, so a back-to-back request is accepted one cycle later.
- rdata_o holds its value until the next load completes.
- Stores leave rdata_o unchanged.
- ce_i dropping during RD_*/WR* (pipeline flush): the transaction still completes. The result is discarded (busy_o already 0), and the FSM returns to IDLE through DONE.
- Never more than one outstanding transaction; AR and AW are never issued concurrently.

Test Plan:
- Load word, addr=0x1C000100, sel=1111, slave arready after 2 cycles, rdata=0x44332211 one cycle later -> arsize=2, busy_o high 4+ cycles, DONE cycle rdata_o=0x11223344, busy_o=0, err_o=0.
- Store byte, addr=0x1C000102, sel=0010, data=0xABABABAB -> awsize=0, wstrb=0100, wdata=0xABABABAB; busy released the cycle after bvalid.
- Store half, sel=1100, data=0x12345678, wready asserted 3 cycles before awready -> wvalid drops after its handshake, awvalid held; wstrb=0011, wdata=0x78563412, exactly one AW and one W handshake.
- Load with rresp=10 (SLVERR) -> err_o pulses exactly once in DONE.
- Back-to-back load then store with ce_i held -> second araddr/awaddr issued one cycle after first DONE; no duplicate transactions.
- rst asserted while in RD_D -> next cycle state IDLE, all valids/readies 0, busy_o=1 if ce_i still high.

Source files
------------

// File: rtl/dmem_axi_bridge.sv
// MEM-stage data memory responder: turns each ce_i request into one single-beat
// AXI4 read or write, stalling the pipeline through busy_o until it completes.
module dmem_axi_bridge #(
  parameter int ID_WIDTH = 4,
  parameter int AXI_ID   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce_i,
  input  logic                we_i,
  input  logic [3:0]          sel_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         data_i,
  output logic                busy_o,
  output logic [31:0]         rdata_o,
  output logic                err_o,
  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arvalid,
  input  logic                arready,
  input  logic [ID_WIDTH-1:0] rid,
  input  logic [31:0]         rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [ID_WIDTH-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awvalid,
  input  logic                awready,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_WIDTH-1:0] bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD_A = 3'd1;
  localparam logic [2:0] RD_D = 3'd2;
  localparam logic [2:0] WR   = 3'd3;
  localparam logic [2:0] WR_B = 3'd4;
  localparam logic [2:0] DONE = 3'd5;

  // MEM lane 3 is the lowest-addressed byte; AXI lane 0 is.
  function automatic logic [31:0] byte_rev(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic logic [3:0] bit_rev4(input logic [3:0] s);
    return {s[0], s[1], s[2], s[3]};
  endfunction

  function automatic logic [2:0] size_of(input logic [3:0] s);
    logic [2:0] sz;
    case (s)
      4'b1111:                            sz = 3'd2;
      4'b1100, 4'b0011:                   sz = 3'd1;
      4'b1000, 4'b0100, 4'b0010, 4'b0001: sz = 3'd0;
      default:                            sz = 3'd2;
    endcase
    return sz;
  endfunction

  logic [2:0]  state_r;
  logic [31:0] addr_r;
  logic [31:0] data_r;
  logic [3:0]  sel_r;
  logic        we_r;
  logic        arvalid_r;
  logic        rready_r;
  logic        awvalid_r;
  logic        wvalid_r;
  logic        bready_r;
  logic [31:0] rdata_r;
  logic        err_r;
  logic        aw_done_s;
  logic        w_done_s;
  logic        unused_s;

  // A write channel is finished once its valid has dropped or is handshaking now.
  assign aw_done_s = !awvalid_r || awready;
  assign w_done_s  = !wvalid_r  || wready;
  assign unused_s  = ^{rid, bid, rlast, we_r};

  // Transaction FSM and AXI handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      addr_r    <= 32'd0;
      data_r    <= 32'd0;
      sel_r     <= 4'd0;
      we_r      <= 1'b0;
      arvalid_r <= 1'b0;
      rready_r  <= 1'b0;
      awvalid_r <= 1'b0;
      wvalid_r  <= 1'b0;
      bready_r  <= 1'b0;
      rdata_r   <= 32'd0;
      err_r     <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (ce_i) begin
            addr_r <= addr_i;
            data_r <= data_i;
            sel_r  <= sel_i;
            we_r   <= we_i;
            if (we_i) begin
              state_r   <= WR;
              awvalid_r <= 1'b1;
              wvalid_r  <= 1'b1;
            end else begin
              state_r   <= RD_A;
              arvalid_r <= 1'b1;
            end
          end
        end
        RD_A: begin
          if (arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= RD_D;
          end
        end
        RD_D: begin
          if (rvalid) begin
            rdata_r  <= byte_rev(rdata);
            err_r    <= (rresp != 2'b00);
            rready_r <= 1'b0;
            state_r  <= DONE;
          end
        end
        WR: begin
          if (awready) begin
            awvalid_r <= 1'b0;
          end
          if (wready) begin
            wvalid_r <= 1'b0;
          end
          if (aw_done_s && w_done_s) begin
            bready_r <= 1'b1;
            state_r  <= WR_B;
          end
        end
        WR_B: begin
          if (bvalid) begin
            err_r    <= (bresp != 2'b00);
            bready_r <= 1'b0;
            state_r  <= DONE;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy_o  = ce_i && (state_r != DONE);
  assign rdata_o = rdata_r;
  assign err_o   = err_r;

  assign arid    = ID_WIDTH'(AXI_ID);
  assign araddr  = addr_r;
  assign arlen   = 8'd0;
  assign arsize  = size_of(sel_r);
  assign arburst = 2'b01;
  assign arvalid = arvalid_r;
  assign rready  = rready_r;

  assign awid    = ID_WIDTH'(AXI_ID);
  assign awaddr  = addr_r;
  assign awlen   = 8'd0;
  assign awsize  = size_of(sel_r);
  assign awburst = 2'b01;
  assign awvalid = awvalid_r;
  assign wdata   = byte_rev(data_r);
  assign wstrb   = bit_rev4(sel_r);
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_r;
  assign bready  = bready_r;

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Directed bench for dmem_axi_bridge: a table of load/store vectors served by a
// delay-programmable AXI slave, plus back-to-back and mid-transaction reset sequences.
module tb_dmem_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i, we_i;
  logic [3:0]  sel_i;
  logic [31:0] addr_i, data_i;
  logic        busy_o, err_o;
  logic [31:0] rdata_o;
  logic [3:0]  arid, rid, awid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]  wstrb;

  int total = 0;
  int bad   = 0;

  dmem_axi_bridge #(.ID_WIDTH(4), .AXI_ID(1)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .sel_i(sel_i), .addr_i(addr_i),
    .data_i(data_i), .busy_o(busy_o), .rdata_o(rdata_o), .err_o(err_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] sdata;     // slave read data (AXI lane order)
    logic [1:0]  resp;
    int          ar_dly;
    int          aw_dly;
    int          w_dly;
    logic [2:0]  exp_size;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_busy;  // cycles busy_o is high, request cycle included
  } vec_t;

  vec_t vecs[7];
  vec_t b2b_ld, b2b_st;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic slave_idle();
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rvalid = 1'b0; bvalid = 1'b0; rdata = 32'd0; rresp = 2'b00; bresp = 2'b00;
  endtask

  task automatic drive_req(input vec_t v);
    ce_i = 1'b1; we_i = v.we; sel_i = v.sel; addr_i = v.addr; data_i = v.data;
  endtask

  // Called in the IDLE cycle with the request already on the inputs.
  task automatic serve(input vec_t v, input bit keep);
    int busy_cnt, ar_hs, aw_hs, w_hs, ar_cnt, aw_cnt, w_cnt;
    bit r_done, b_done, done, err_early, ar_chk, aw_chk, w_chk;
    busy_cnt = 1; ar_hs = 0; aw_hs = 0; w_hs = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    r_done = 0; b_done = 0; done = 0; err_early = 0; ar_chk = 0; aw_chk = 0; w_chk = 0;
    #1;
    check("busy_req", busy_o, 1'b1);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!busy_o) begin
        done = 1;
        slave_idle();
      end else begin
        busy_cnt++;
        if (err_o) err_early = 1;
        if (arvalid && !ar_chk) begin
          ar_chk = 1;
          check("ar_fields", {arid, araddr, arlen, arsize, arburst},
                {4'd1, v.addr, 8'd0, v.exp_size, 2'b01});
        end
        if (awvalid && !aw_chk) begin
          aw_chk = 1;
          check("aw_fields", {awid, awaddr, awlen, awsize, awburst},
                {4'd1, v.addr, 8'd0, v.exp_size, 2'b01});
        end
        if (wvalid && !w_chk) begin
          w_chk = 1;
          check("w_fields", {wdata, wstrb, wlast}, {v.exp_wdata, v.exp_strb, 1'b1});
        end
        if (ar_hs > 0) check("ar_drop", arvalid, 1'b0);
        if (aw_hs > 0) check("aw_drop", awvalid, 1'b0);
        if (w_hs > 0)  check("w_drop", wvalid, 1'b0);
        // responses depend only on handshakes from earlier cycles
        rvalid = (ar_hs > 0) && !r_done;
        rdata  = v.sdata;
        rresp  = v.resp;
        if (rvalid) begin
          check("rready", rready, 1'b1);
          r_done = rready;
        end
        bvalid = (aw_hs > 0) && (w_hs > 0) && !b_done;
        bresp  = v.resp;
        if (bvalid) begin
          check("bready", bready, 1'b1);
          b_done = bready;
        end
        arready = arvalid && (ar_cnt >= v.ar_dly);
        awready = awvalid && (aw_cnt >= v.aw_dly);
        wready  = wvalid  && (w_cnt  >= v.w_dly);
        if (arvalid) ar_cnt++;
        if (awvalid) aw_cnt++;
        if (wvalid)  w_cnt++;
        if (arvalid && arready) ar_hs++;
        if (awvalid && awready) aw_hs++;
        if (wvalid && wready)   w_hs++;
      end
    end
    check("done_seen", done, 1'b1);
    if (done) begin
      check("busy_cycles", busy_cnt, v.exp_busy);
      check("rdata_o", rdata_o, v.exp_rdata);
      check("err_done", err_o, v.exp_err);
      check("err_early", err_early, 1'b0);
      check("ar_count", ar_hs, v.we ? 0 : 1);
      check("aw_count", aw_hs, v.we ? 1 : 0);
      check("w_count", w_hs, v.we ? 1 : 0);
      if (!keep) begin
        ce_i = 1'b0;
        @(negedge clk);
        check("err_after", err_o, 1'b0);
        check("idle_quiet", {busy_o, arvalid, awvalid, wvalid, rready, bready}, 6'd0);
      end
    end
  endtask

  initial begin
    //          we    sel      addr          data          sdata         resp  ar aw w  size  strb     wdata         rdata         err   busy
    vecs[0] = '{1'b0, 4'b1111, 32'h1C000100, 32'h00000000, 32'h44332211, 2'b00, 2, 0, 0, 3'd2, 4'b0000, 32'h00000000, 32'h11223344, 1'b0, 5};
    vecs[1] = '{1'b1, 4'b0010, 32'h1C000102, 32'hABABABAB, 32'h00000000, 2'b00, 0, 0, 0, 3'd0, 4'b0100, 32'hABABABAB, 32'h11223344, 1'b0, 3};
    vecs[2] = '{1'b1, 4'b1100, 32'h1C000200, 32'h12345678, 32'h00000000, 2'b00, 0, 3, 0, 3'd1, 4'b0011, 32'h78563412, 32'h11223344, 1'b0, 6};
    vecs[3] = '{1'b0, 4'b0011, 32'h1C000204, 32'h00000000, 32'hA1B2C3D4, 2'b10, 0, 0, 0, 3'd1, 4'b0000, 32'h00000000, 32'hD4C3B2A1, 1'b1, 3};
    vecs[4] = '{1'b0, 4'b0100, 32'h1C000101, 32'h00000000, 32'h00EE0000, 2'b00, 1, 0, 0, 3'd0, 4'b0000, 32'h00000000, 32'h0000EE00, 1'b0, 4};
    vecs[5] = '{1'b1, 4'b1010, 32'h1C000208, 32'hCAFEF00D, 32'h00000000, 2'b11, 0, 1, 2, 3'd2, 4'b0101, 32'h0DF0FECA, 32'h0000EE00, 1'b1, 5};
    vecs[6] = '{1'b1, 4'b1111, 32'h1C00020C, 32'h01020304, 32'h00000000, 2'b00, 0, 0, 0, 3'd2, 4'b1111, 32'h04030201, 32'h0000EE00, 1'b0, 3};
    b2b_ld  = '{1'b0, 4'b1111, 32'h1C000300, 32'h00000000, 32'h87654321, 2'b00, 0, 0, 0, 3'd2, 4'b0000, 32'h00000000, 32'h21436587, 1'b0, 3};
    b2b_st  = '{1'b1, 4'b0001, 32'h1C000304, 32'h000000FF, 32'h00000000, 2'b00, 0, 0, 0, 3'd0, 4'b1000, 32'hFF000000, 32'h21436587, 1'b0, 3};

    rst = 1'b1; ce_i = 1'b0; we_i = 1'b0; sel_i = 4'd0; addr_i = 32'd0; data_i = 32'd0;
    rid = 4'd0; bid = 4'd0; rlast = 1'b1;
    slave_idle();
    repeat (3) @(negedge clk);
    check("reset_ctl", {busy_o, err_o, arvalid, awvalid, wvalid, rready, bready}, 7'd0);
    check("reset_rdata", rdata_o, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive_req(vecs[i]);
      serve(vecs[i], 1'b0);
    end

    // back-to-back load then store with ce_i held through DONE
    @(negedge clk);
    drive_req(b2b_ld);
    serve(b2b_ld, 1'b1);
    drive_req(b2b_st);
    @(negedge clk);
    check("b2b_idle", {busy_o, arvalid, awvalid}, 3'b100);
    serve(b2b_st, 1'b0);

    // reset while waiting for read data
    @(negedge clk);
    drive_req(vecs[0]);
    @(negedge clk);
    check("rst_seq_arvalid", arvalid, 1'b1);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check("rst_seq_rready", rready, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ctl", {arvalid, awvalid, wvalid, rready, bready, err_o}, 6'd0);
    check("rst_mid_busy", busy_o, 1'b1);
    check("rst_mid_rdata", rdata_o, 32'd0);
    rst = 1'b0;
    ce_i = 1'b0;
    @(negedge clk);
    drive_req(vecs[0]);
    serve(vecs[0], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
